// File: rtl/store_queue.sv
// store_queue: in-order store buffer between the AGU and the D-cache/IO write port, with load-conflict lookup.
// Latency: enqueue at edge N is committable in N+1; commit at edge N raises dc_req_o in N+1 (2 cycles minimum).
// Backpressure: enqueue_full_o stalls the AGU; dc_req_o and its payload hold steady until dc_ack_i.
module store_queue #(
    parameter int DEPTH = 8
) (
    input  logic        cpu_clock_i,
    input  logic        cpu_resetn_i,
    input  logic        flush_i,
    input  logic        enqueue_en_i,
    input  logic [29:0] enqueue_address_i,
    input  logic [31:0] enqueue_data_i,
    input  logic [3:0]  enqueue_bm_i,
    input  logic        enqueue_io_i,
    input  logic [4:0]  enqueue_rob_i,
    output logic        enqueue_full_o,
    input  logic [29:0] conflict_address_i,
    input  logic [3:0]  conflict_bm_i,
    output logic        conflict_o,
    input  logic        commit_vld_i,
    output logic        dc_req_o,
    output logic [29:0] dc_addr_o,
    output logic [31:0] dc_data_o,
    output logic [3:0]  dc_bm_o,
    output logic        dc_io_o,
    input  logic        dc_ack_i,
    output logic        empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PW-1:0] head_q;
    logic [PW-1:0] cmt_q;
    logic [PW-1:0] tail_q;
    logic [PW-1:0] head_nxt;
    logic [PW-1:0] cmt_nxt;
    logic [PW-1:0] tail_nxt;
    logic [PW-1:0] occupied;

    logic [AW-1:0] head_idx;
    logic [AW-1:0] tail_idx;

    // Entry storage; contents are never reset, liveness comes from the pointers.
    logic [29:0] addr_q [DEPTH];
    logic [31:0] data_q [DEPTH];
    logic [3:0]  bm_q   [DEPTH];
    logic        io_q   [DEPTH];
    logic [4:0]  rob_q  [DEPTH];

    logic enq_fire;
    logic cmt_fire;
    logic ack_fire;

    logic [DEPTH-1:0] slot_live;
    logic [DEPTH-1:0] slot_hit;

    // Head entry's ROB tag, a tap point for trace logic.
    logic [4:0] trace_head_rob_unused;

    assign head_idx = head_q[AW-1:0];
    assign tail_idx = tail_q[AW-1:0];

    // Status is derived from registered pointers only.
    assign occupied       = tail_q - head_q;
    assign enqueue_full_o = (occupied == PW'(DEPTH));
    assign empty_o        = (head_q == tail_q);
    assign dc_req_o       = (head_q != cmt_q);

    // Head payload straight from the array so it is stable while unacked.
    assign dc_addr_o = addr_q[head_idx];
    assign dc_data_o = data_q[head_idx];
    assign dc_bm_o   = bm_q[head_idx];
    assign dc_io_o   = io_q[head_idx];
    assign trace_head_rob_unused = rob_q[head_idx];

    // Commit compares against the registered tail, so a same-cycle enqueue cannot be committed.
    assign enq_fire = enqueue_en_i & ~enqueue_full_o & ~flush_i;
    assign cmt_fire = commit_vld_i & (cmt_q != tail_q);
    assign ack_fire = dc_req_o & dc_ack_i;

    // Next pointer values; flush pulls tail back to the post-commit cmt.
    always_comb begin
        head_nxt = ack_fire ? head_q + PW'(1) : head_q;
        cmt_nxt  = cmt_fire ? cmt_q + PW'(1) : cmt_q;
        tail_nxt = tail_q;
        if (flush_i) begin
            tail_nxt = cmt_nxt;
        end else if (enq_fire) begin
            tail_nxt = tail_q + PW'(1);
        end
    end

    // Pointer registers; reset discards every entry including committed ones.
    always_ff @(posedge cpu_clock_i or negedge cpu_resetn_i) begin
        if (!cpu_resetn_i) begin
            head_q <= '0;
            cmt_q  <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_nxt;
            cmt_q  <= cmt_nxt;
            tail_q <= tail_nxt;
        end
    end

    // Write the accepted store into the slot at tail.
    always_ff @(posedge cpu_clock_i) begin
        if (enq_fire) begin
            addr_q[tail_idx] <= enqueue_address_i;
            data_q[tail_idx] <= enqueue_data_i;
            bm_q[tail_idx]   <= enqueue_bm_i;
            io_q[tail_idx]   <= enqueue_io_i;
            rob_q[tail_idx]  <= enqueue_rob_i;
        end
    end

    // Per-slot liveness (distance from head below occupancy) gated address/byte overlap.
    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        logic [AW-1:0] off;
        assign off          = AW'(g) - head_idx;
        assign slot_live[g] = ({1'b0, off} < occupied);
        assign slot_hit[g]  = slot_live[g]
                            & (addr_q[g] == conflict_address_i)
                            & (|(bm_q[g] & conflict_bm_i));
    end

    assign conflict_o = |slot_hit;

endmodule

// File: tb/tb_store_queue.sv
// tb_store_queue: randomized + directed bench for store_queue with queue-based reference model.
// Latency: model updates on each rising edge; status checked on the falling edge.
// Backpressure: drain expectations queue in a scoreboard popped by a separate monitor on ack.
module tb_store_queue;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        en;
    logic [29:0] e_addr;
    logic [31:0] e_data;
    logic [3:0]  e_bm;
    logic        e_io;
    logic [4:0]  e_rob;
    logic        full;
    logic [29:0] c_addr;
    logic [3:0]  c_bm;
    logic        conflict;
    logic        commit;
    logic        dc_req;
    logic [29:0] dc_addr;
    logic [31:0] dc_data;
    logic [3:0]  dc_bm;
    logic        dc_io;
    logic        ack;
    logic        empty;

    always #5 clk = ~clk;

    store_queue #(.DEPTH(DEPTH)) dut (
        .cpu_clock_i        (clk),
        .cpu_resetn_i       (rst_n),
        .flush_i            (flush),
        .enqueue_en_i       (en),
        .enqueue_address_i  (e_addr),
        .enqueue_data_i     (e_data),
        .enqueue_bm_i       (e_bm),
        .enqueue_io_i       (e_io),
        .enqueue_rob_i      (e_rob),
        .enqueue_full_o     (full),
        .conflict_address_i (c_addr),
        .conflict_bm_i      (c_bm),
        .conflict_o         (conflict),
        .commit_vld_i       (commit),
        .dc_req_o           (dc_req),
        .dc_addr_o          (dc_addr),
        .dc_data_o          (dc_data),
        .dc_bm_o            (dc_bm),
        .dc_io_o            (dc_io),
        .dc_ack_i           (ack),
        .empty_o            (empty)
    );

    typedef struct packed {
        logic [29:0] a;
        logic [31:0] d;
        logic [3:0]  bm;
        logic        io;
    } ent_t;

    // Reference model: held stores in age order, count of committed ones at the front.
    ent_t sq[$];
    int   ncmt;
    // Scoreboard: stores the memory port must see, in order.
    ent_t exp_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic logic m_conflict();
        foreach (sq[i]) begin
            if (sq[i].a == c_addr && (sq[i].bm & c_bm) != 4'd0) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic check_status();
        chk("full",     {31'd0, full},     {31'd0, sq.size() == DEPTH});
        chk("empty",    {31'd0, empty},    {31'd0, sq.size() == 0});
        chk("dc_req",   {31'd0, dc_req},   {31'd0, ncmt > 0});
        chk("conflict", {31'd0, conflict}, {31'd0, m_conflict()});
    endtask

    // Apply one clock edge's worth of rules to the model, using the driven inputs.
    task automatic model_update();
        int   sz;
        int   nc;
        int   keep;
        bit   c_ok;
        bit   a_ok;
        bit   e_ok;
        ent_t ne;
        sz   = sq.size();
        nc   = ncmt;
        c_ok = commit && (nc < sz);
        a_ok = ack && (nc > 0);
        e_ok = en && (sz < DEPTH) && !flush;
        if (c_ok) exp_q.push_back(sq[nc]);
        keep = nc + int'(c_ok);
        if (flush) begin
            while (sq.size() > keep) sq.delete(sq.size() - 1);
        end
        if (a_ok) sq.delete(0);
        if (e_ok) begin
            ne.a  = e_addr;
            ne.d  = e_data;
            ne.bm = e_bm;
            ne.io = e_io;
            sq.push_back(ne);
        end
        ncmt = keep - int'(a_ok);
    endtask

    task automatic step();
        @(negedge clk);
        check_status();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        flush  = 1'b0;
        en     = 1'b0;
        commit = 1'b0;
        ack    = 1'b0;
    endtask

    task automatic set_enq(input logic [29:0] a, input logic [3:0] bm);
        en     = 1'b1;
        e_addr = a;
        e_bm   = bm;
        e_data = $urandom;
        e_io   = 1'($urandom_range(0, 1));
        e_rob  = 5'($urandom_range(0, 31));
    endtask

    // Commit and ack everything held; bounded so a stuck DUT still reaches the summary.
    task automatic drain();
        int n;
        idle();
        commit = 1'b1;
        ack    = 1'b1;
        n = 0;
        while ((sq.size() != 0 || dc_req) && n < 4 * DEPTH) begin
            step();
            n++;
        end
        idle();
        chk("drain_empty", {31'd0, empty}, 32'd1);
        chk("drain_sb_left", exp_q.size(), 0);
    endtask

    // Monitor: whenever a request is presented, its payload must match the oldest expected store.
    always @(negedge clk) begin
        if (rst_n && dc_req) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL dc_unexpected: got request addr %h, none expected at %0t", dc_addr, $time);
            end else begin
                chk("dc_addr", {2'b0, dc_addr}, {2'b0, exp_q[0].a});
                chk("dc_data", dc_data, exp_q[0].d);
                chk("dc_bm",   {28'd0, dc_bm}, {28'd0, exp_q[0].bm});
                chk("dc_io",   {31'd0, dc_io}, {31'd0, exp_q[0].io});
                if (ack) exp_q.delete(0);
            end
        end
    end

    initial begin
        idle();
        rst_n  = 1'b0;
        e_addr = '0;
        e_data = '0;
        e_bm   = '0;
        e_io   = 1'b0;
        e_rob  = '0;
        c_addr = '0;
        c_bm   = '0;
        ncmt   = 0;
        #12;
        chk("rst_empty",  {31'd0, empty},    32'd1);
        chk("rst_full",   {31'd0, full},     32'd0);
        chk("rst_dc_req", {31'd0, dc_req},   32'd0);
        chk("rst_confl",  {31'd0, conflict}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single store end to end.
        set_enq(30'h100, 4'b0001);
        e_data = 32'hAA;
        step();
        idle();
        chk("t1_empty",  {31'd0, empty},  32'd0);
        chk("t1_no_req", {31'd0, dc_req}, 32'd0);
        commit = 1'b1;
        step();
        idle();
        chk("t1_req",  {31'd0, dc_req}, 32'd1);
        chk("t1_addr", {2'b0, dc_addr}, 32'h100);
        chk("t1_bm",   {28'd0, dc_bm},  32'd1);
        chk("t1_data", dc_data,         32'hAA);
        ack = 1'b1;
        step();
        idle();
        chk("t1_drained", {31'd0, empty}, 32'd1);

        // Fill, overflow attempt, then wrap-around traffic.
        for (int i = 0; i < DEPTH; i++) begin
            set_enq(30'h300 + 30'(i), 4'b1111);
            step();
        end
        chk("t2_full", {31'd0, full}, 32'd1);
        set_enq(30'h3FF, 4'b1111);
        step();
        idle();
        chk("t2_still_full", {31'd0, full}, 32'd1);
        commit = 1'b1;
        step();
        idle();
        ack = 1'b1;
        step();
        idle();
        chk("t2_not_full", {31'd0, full}, 32'd0);
        for (int i = 0; i < 20; i++) begin
            set_enq(30'h400 + 30'(i), 4'($urandom_range(1, 15)));
            commit = 1'b1;
            ack    = 1'b1;
            step();
        end
        drain();

        // Flush keeps committed stores, drops the rest and the same-cycle enqueue.
        for (int i = 0; i < 4; i++) begin
            set_enq(30'h500 + 30'(i), 4'b0011);
            step();
        end
        idle();
        commit = 1'b1;
        step();
        step();
        idle();
        flush = 1'b1;
        set_enq(30'h5FF, 4'b0011);
        step();
        idle();
        chk("t3_req_kept", {31'd0, dc_req}, 32'd1);
        ack = 1'b1;
        step();
        step();
        idle();
        chk("t3_flushed_gone", {31'd0, empty}, 32'd1);
        chk("t3_no_req", {31'd0, dc_req}, 32'd0);

        // Conflict queries against one uncommitted store.
        set_enq(30'h40, 4'b1100);
        step();
        idle();
        c_addr = 30'h40; c_bm = 4'b0100; #1;
        chk("t4_hit", {31'd0, conflict}, 32'd1);
        c_addr = 30'h40; c_bm = 4'b0011; #1;
        chk("t4_bm_miss", {31'd0, conflict}, 32'd0);
        c_addr = 30'h44; c_bm = 4'b1100; #1;
        chk("t4_addr_miss", {31'd0, conflict}, 32'd0);
        c_addr = 30'h40; c_bm = 4'b1100;
        drain();
        #1;
        chk("t4_stale_miss", {31'd0, conflict}, 32'd0);

        // Stall drain for 5 cycles; commits with nothing uncommitted do nothing.
        set_enq(30'h60, 4'b1010);
        step();
        idle();
        commit = 1'b1;
        step();
        for (int i = 0; i < 5; i++) step();
        idle();
        set_enq(30'h61, 4'b0101);
        step();
        idle();
        ack = 1'b1;
        step();
        idle();
        chk("t5_no_phantom_commit", {31'd0, dc_req}, 32'd0);
        chk("t5_one_held", {31'd0, empty}, 32'd0);
        drain();

        // Reset in the middle of a drain.
        for (int i = 0; i < 3; i++) begin
            set_enq(30'h700 + 30'(i), 4'b1111);
            step();
        end
        idle();
        commit = 1'b1;
        step();
        step();
        step();
        idle();
        ack = 1'b1;
        step();
        idle();
        rst_n = 1'b0;
        #1;
        chk("t6_rst_empty",  {31'd0, empty},  32'd1);
        chk("t6_rst_full",   {31'd0, full},   32'd0);
        chk("t6_rst_dc_req", {31'd0, dc_req}, 32'd0);
        sq.delete();
        exp_q.delete();
        ncmt = 0;
        @(posedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_post_empty", {31'd0, empty}, 32'd1);

        // Random mix of everything, including flushes and conflict probes.
        for (int i = 0; i < 500; i++) begin
            en     = 1'($urandom_range(0, 9) < 6);
            e_addr = 30'h200 + 30'($urandom_range(0, 5));
            e_data = $urandom;
            e_bm   = 4'($urandom_range(1, 15));
            e_io   = 1'($urandom_range(0, 1));
            e_rob  = 5'($urandom_range(0, 31));
            commit = 1'($urandom_range(0, 1));
            ack    = 1'($urandom_range(0, 9) < 6);
            flush  = 1'($urandom_range(0, 15) == 0);
            c_addr = 30'h200 + 30'($urandom_range(0, 5));
            c_bm   = 4'($urandom_range(0, 15));
            step();
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/store_queue.md
# store_queue

In-order store buffer directly downstream of the load/store address-generation stage. It accepts translated, byte-aligned stores from the AGU enqueue port and holds them until the ROB commits them. It drains committed stores one at a time to the data-cache/IO write port. It also answers the AGU's load conflict query against every held store.

## Interface
- DEPTH, 8, entry count; power of two, ≥2; pointers are log2(DEPTH)+1 bits (extra wrap bit)
- cpu_clock_i  in  1  clock, all state on rising edge
- cpu_resetn_i  in  1  asynchronous active-low reset
- flush_i  in  1  pipeline flush; discards uncommitted entries
- enqueue_en_i  in  1  store valid from AGU
- enqueue_address_i  in  30  word address [31:2]
- enqueue_data_i  in  32  byte-lane-positioned store data
- enqueue_bm_i  in  4  byte mask
- enqueue_io_i  in  1  IO (uncached) store
- enqueue_rob_i  in  5  ROB tag (kept for debug/trace only)
- enqueue_full_o  out  1  no free entry; AGU holds its enqueue registers
- conflict_address_i  in  30  load word address to check
- conflict_bm_i  in  4  load byte mask
- conflict_o  out  1  some held store overlaps the load
- commit_vld_i  in  1  ROB retired the oldest uncommitted store
- dc_req_o  out  1  committed store presented to memory
- dc_addr_o  out  30  word address of the head entry
- dc_data_o  out  32  data of the head entry
- dc_bm_o  out  4  byte mask of the head entry
- dc_io_o  out  1  IO flag of the head entry
- dc_ack_i  in  1  memory accepted the head entry
- empty_o  out  1  no entries held

## Operation
- Storage is a circular array with three pointers, oldest to youngest: head (drain), cmt (commit) and tail (allocate). Invariant: head ≤ cmt ≤ tail (modular); tail−head ≤ DEPTH.
- Occupied = tail−head; enqueue_full_o = (occupied == DEPTH); empty_o = (occupied == 0). Both come from registered pointers only.
- Enqueue: enqueue_en_i & !enqueue_full_o & !flush_i writes the entry at tail, then tail+1.
  - Enqueue while full is ignored; the AGU holds and re-presents.
  - Enqueue in a flush cycle is dropped.
- Commit: commit_vld_i & (cmt != tail) sets cmt+1. The tail used here is the registered value.
  - Commit with no uncommitted entry is ignored.
  - Commit of an entry enqueued in the same cycle is therefore ignored.
- Drain: dc_req_o = (head != cmt). dc_addr/data/bm/io_o show the entry at head, combinationally from the array.
  - On dc_req_o & dc_ack_i, head+1.
  - The request and its payload stay stable until acked. dc_ack_i without dc_req_o is ignored.
- Flush: tail ← cmt after applying any same-cycle commit.
  - Committed entries survive and keep draining.
  - An outstanding dc_req_o is unaffected.
- Conflict: conflict_o = OR over occupied entries i (head ≤ i < tail, committed or not) of (addr_i == conflict_address_i) & |(bm_i & conflict_bm_i). Purely combinational. Unoccupied slots never match, regardless of stale contents.
- Pointer arithmetic wraps modulo 2·DEPTH. The index is the low log2(DEPTH) bits; the wrap bit distinguishes full from empty.

## Timing
- Reset (async assert, sync-safe deassert):
  - head = cmt = tail = 0.
  - enqueue_full_o = 0, empty_o = 1, dc_req_o = 0, conflict_o = 0.
  - dc_* payload outputs are don't-care. Array contents are not reset.
- Reset mid-operation discards all entries, committed ones included.
- Enqueue at edge N: the entry is visible to conflict_o and empty_o from cycle N+1, and committable from cycle N+1.
- Commit at edge N: dc_req_o can rise in cycle N+1.
- Minimum enqueue→dc_req_o latency is 2 cycles.
- One ack per cycle gives drain throughput of 1 store/cycle.
- Simultaneous enqueue, commit, ack and flush in one cycle are all legal. Each updates its own pointer per the rules above.
- A same-cycle ack does not clear enqueue_full_o until the next cycle.

## Test plan
- Reset → empty_o=1, enqueue_full_o=0, dc_req_o=0. Enqueue addr=0x100, bm=0001, data=0xAA → next cycle empty_o=0, dc_req_o=0. commit_vld_i → next cycle dc_req_o=1, dc_addr_o=0x100, dc_bm_o=0001. Ack → empty_o=1.
- DEPTH=8: enqueue 8 stores with no commits → enqueue_full_o=1. A 9th enqueue_en_i is ignored (tail unchanged). Commit 1 and ack 1 → enqueue_full_o=0 the following cycle. 20 further enqueue/commit/ack rounds leave data in order across the pointer wrap.
- Enqueue 4 stores, commit 2, assert flush_i → tail=cmt. The 2 committed stores still drain with correct payloads; the 2 flushed stores never appear on dc_*. A same-cycle enqueue with flush is dropped.
- Held store addr=0x40, bm=1100: conflict query 0x40/0100 → conflict_o=1; 0x40/0011 → 0; 0x44/1100 → 0. After that store drains → 0x40/1100 returns 0.
- Hold dc_ack_i=0 for 5 cycles with dc_req_o=1 → payload stable. Commit_vld_i with cmt==tail → no effect.
- Assert cpu_resetn_i low mid-drain with 3 entries held → outputs return to reset values immediately; empty_o=1 after release.
